// File: rtl/dma_fifo_pkg.sv
// dma_fifo_pkg: shared types and constants for the DMA FIFO and channel status register
package dma_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fifo_state_t;

    // bit positions of the sticky error flags, mirrored in the channel status register
    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_W   = 2;

    function automatic int fifo_clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dma_fifo_ram.sv
// dma_fifo_ram: simple dual-port RAM with registered read, array not reset
module dma_fifo_ram #(
    parameter int WIDTH = 128,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    // write port and one-cycle-latency read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: single-clock DMA FIFO with flags, sticky errors, flush and optional FWFT
module dma_sync_fifo
    import dma_fifo_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int DEPTH_LOG2 = 7,
    parameter int FWFT       = 1,
    parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  CLR,
    input  logic                  WEN,
    input  logic [WIDTH-1:0]      WDATA,
    input  logic                  REN,
    output logic [WIDTH-1:0]      RDATA,
    output logic                  RVALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = fifo_clog2(DEPTH) + 1;

    if (AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_level_chk
        $error("dma_sync_fifo: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
    end

    fifo_state_t      state_q, state_d;
    logic [PW-1:0]    wr_ptr, rd_ptr, count_q, count_d;
    logic [WIDTH-1:0] ram_q;
    logic [ERR_W-1:0] err_q, err_set;
    logic             wr_ok, rd_ok, ram_empty, fetch, ram_re, load;
    logic             rd_pend, rvalid_q, empty_q, full_q, af_q, ae_q;

    assign ram_empty = wr_ptr == rd_ptr;
    assign wr_ok     = WEN && !full_q && !CLR;
    assign rd_ok     = REN && !EMPTY && !CLR;
    // FWFT reads the RAM only to refill the output register; standard mode reads on request
    assign ram_re    = FWFT != 0 ? fetch : rd_ok;
    assign load      = !CLR && (FWFT != 0 ? state_q == ST_FETCH : rd_pend);
    assign count_d   = CLR ? '0 : count_q + PW'(wr_ok) - PW'(rd_ok);

    assign EMPTY        = FWFT != 0 ? state_q != ST_VALID : empty_q;
    assign RVALID       = FWFT != 0 ? state_q == ST_VALID : rvalid_q;
    assign FULL         = full_q;
    assign ALMOST_FULL  = af_q;
    assign ALMOST_EMPTY = ae_q;
    assign COUNT        = count_q;
    assign OVERFLOW     = err_q[ERR_OVF];
    assign UNDERFLOW    = err_q[ERR_UNF];

    dma_fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .clk   (CLOCK),
        .we    (wr_ok),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (WDATA),
        .re    (ram_re),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (ram_q)
    );

    // prefetch FSM state register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // prefetch next-state: keep the output register topped up from the RAM
    always_comb begin
        state_d = state_q;
        fetch   = 1'b0;
        if (CLR || FWFT == 0) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    fetch   = !ram_empty;
                    state_d = ram_empty ? ST_IDLE : ST_FETCH;
                end
                ST_FETCH: state_d = ST_VALID;
                ST_VALID: begin
                    if (rd_ok) begin
                        fetch   = !ram_empty;
                        state_d = ram_empty ? ST_IDLE : ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // RAM pointers, rolling over naturally modulo 2*DEPTH
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET || CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(wr_ok);
            rd_ptr <= rd_ptr + PW'(ram_re);
        end
    end

    // occupancy and registered flags, all derived from the next count
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= count_d == PW'(DEPTH);
            af_q    <= count_d >= PW'(AF_LEVEL);
            ae_q    <= count_d <= PW'(AE_LEVEL);
            empty_q <= count_d == '0;
        end
    end

    // error conditions raised this cycle, regardless of what else is requested
    always_comb begin
        err_set          = '0;
        err_set[ERR_OVF] = WEN && full_q;
        err_set[ERR_UNF] = REN && EMPTY;
    end

    // sticky errors, cleared only by flush or reset
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) err_q <= '0;
        else err_q <= CLR ? '0 : err_q | err_set;
    end

    // output data register: loads the RAM word one edge after it was read
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rd_pend  <= 1'b0;
            rvalid_q <= 1'b0;
            RDATA    <= '0;
        end else begin
            rd_pend  <= rd_ok;
            rvalid_q <= rd_pend && !CLR;
            if (load) RDATA <= ram_q;
        end
    end

endmodule

// File: tb/tb_dma_sync_fifo.sv
// tb_dma_sync_fifo: directed checks of the DMA FIFO in FWFT and standard modes
module tb_dma_sync_fifo;

    logic        clk = 1'b0;
    logic        rst, clr, wen, ren;
    logic [31:0] wdata;

    logic [31:0] f_rdata, s_rdata;
    logic        f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic        s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0]  f_count, s_count;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] RST_VEC = {20'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    dma_sync_fifo #(
        .WIDTH(32), .DEPTH_LOG2(4), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)
    ) u_fwft (
        .CLOCK(clk), .RESET(rst), .CLR(clr), .WEN(wen), .WDATA(wdata), .REN(ren),
        .RDATA(f_rdata), .RVALID(f_rvalid), .FULL(f_full), .EMPTY(f_empty),
        .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae), .COUNT(f_count),
        .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
    );

    dma_sync_fifo #(
        .WIDTH(32), .DEPTH_LOG2(4), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)
    ) u_std (
        .CLOCK(clk), .RESET(rst), .CLR(clr), .WEN(wen), .WDATA(wdata), .REN(ren),
        .RDATA(s_rdata), .RVALID(s_rvalid), .FULL(s_full), .EMPTY(s_empty),
        .ALMOST_FULL(s_af), .ALMOST_EMPTY(s_ae), .COUNT(s_count),
        .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
    );

    function automatic logic [63:0] f_vec();
        return {20'b0, f_rdata, f_rvalid, f_full, f_empty, f_af, f_ae, f_count, f_ovf, f_unf};
    endfunction

    function automatic logic [63:0] s_vec();
        return {20'b0, s_rdata, s_rvalid, s_full, s_empty, s_af, s_ae, s_count, s_ovf, s_unf};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            wen = 1'b1; wdata = base + i;
            step(1);
        end
        wen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
        step(2);
        chk("reset_fwft", f_vec(), RST_VEC);
        chk("reset_std", s_vec(), RST_VEC);
        rst = 1'b0;
        step(1);

        // fill to full with flag thresholds, then overflow
        for (int i = 0; i < 16; i++) begin
            wen = 1'b1; wdata = 32'hA0 + i;
            step(1);
            if (i == 1)  chk("ae_at_2", 64'(f_ae), 64'd1);
            if (i == 2)  chk("ae_at_3", 64'(f_ae), 64'd0);
            if (i == 10) chk("af_at_11", 64'(f_af), 64'd0);
            if (i == 11) chk("af_at_12", 64'(f_af), 64'd1);
            if (i == 14) chk("full_at_15", 64'(f_full), 64'd0);
        end
        chk("count_16", 64'(f_count), 64'd16);
        chk("full_16", 64'(f_full), 64'd1);
        chk("ovf_before", 64'(f_ovf), 64'd0);
        step(1);
        wen = 1'b0;
        chk("ovf_fwft", 64'({f_ovf, f_count}), {58'd0, 1'b1, 5'd16});
        chk("ovf_std", 64'({s_ovf, s_count}), {58'd0, 1'b1, 5'd16});

        // FWFT write-to-read latency
        do_reset();
        wen = 1'b1; wdata = 32'h1234;
        step(1);
        wen = 1'b0;
        chk("fwft_empty_n", 64'(f_empty), 64'd1);
        step(1);
        chk("fwft_empty_n1", 64'(f_empty), 64'd1);
        step(1);
        chk("fwft_head", 64'({f_empty, f_rvalid, f_count, f_rdata}), {25'd0, 1'b0, 1'b1, 5'd1, 32'h1234});
        ren = 1'b1;
        step(1);
        ren = 1'b0;
        chk("fwft_pop", 64'({f_empty, f_count, f_unf}), {57'd0, 1'b1, 5'd0, 1'b0});

        // standard mode: two-edge read latency, then underflow
        do_reset();
        wen = 1'b1; wdata = 32'hC0;
        step(1);
        chk("std_empty_fall", 64'(s_empty), 64'd0);
        fill(2, 32'hC1);
        ren = 1'b1;
        step(1);
        chk("std_e1", 64'({s_rvalid, s_unf}), 64'd0);
        step(1);
        chk("std_w0", 64'({s_rvalid, s_rdata}), {31'd0, 1'b1, 32'hC0});
        step(1);
        chk("std_w1", 64'({s_rvalid, s_rdata}), {31'd0, 1'b1, 32'hC1});
        step(1);
        chk("std_w2", 64'({s_rvalid, s_rdata}), {31'd0, 1'b1, 32'hC2});
        chk("std_unf", 64'({s_unf, s_count}), {58'd0, 1'b1, 5'd0});
        ren = 1'b0;
        step(1);
        chk("std_hold", 64'({s_rvalid, s_rdata}), {31'd0, 1'b0, 32'hC2});

        // pointer wrap with steady occupancy of five
        do_reset();
        fill(5, 32'h100);
        step(2);
        for (int k = 0; k < 40; k++) begin
            chk("wrap_data", 64'({f_count, f_rdata}), {27'd0, 5'd5, 32'h100 + k});
            wen = 1'b1; ren = 1'b1; wdata = 32'h105 + k;
            step(1);
            wen = 1'b0; ren = 1'b0;
            step(2);
        end
        chk("wrap_std_count", 64'(s_count), 64'd5);

        // simultaneous write+read at full: read wins, write dropped
        do_reset();
        fill(16, 32'hA0);
        step(2);
        chk("full_head", 64'(f_rdata), 64'hA0);
        wen = 1'b1; ren = 1'b1; wdata = 32'hBB;
        step(1);
        wen = 1'b0; ren = 1'b0;
        chk("full_wr_rd_fwft", 64'({f_ovf, f_full, f_count}), {57'd0, 1'b1, 1'b0, 5'd15});
        chk("full_wr_rd_std", 64'({s_ovf, s_full, s_count}), {57'd0, 1'b1, 1'b0, 5'd15});

        // simultaneous write+read at empty: write accepted, underflow flagged
        do_reset();
        wen = 1'b1; ren = 1'b1; wdata = 32'h55;
        step(1);
        wen = 1'b0; ren = 1'b0;
        chk("empty_wr_rd_fwft", 64'({f_unf, f_count}), {58'd0, 1'b1, 5'd1});
        chk("empty_wr_rd_std", 64'({s_unf, s_count}), {58'd0, 1'b1, 5'd1});
        step(2);
        chk("empty_wr_rd_data", 64'({f_empty, f_rdata}), {31'd0, 1'b0, 32'h55});

        // flush with nine words held and both errors set
        do_reset();
        ren = 1'b1;
        step(1);
        ren = 1'b0;
        fill(16, 32'hA0);
        wen = 1'b1; wdata = 32'hEE;
        step(1);
        wen = 1'b0;
        ren = 1'b1;
        step(7);
        ren = 1'b0;
        step(1);
        chk("pre_clr", 64'({s_ovf, s_unf, s_count, s_rdata}), {25'd0, 1'b1, 1'b1, 5'd9, 32'hA6});
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_std", 64'({s_ovf, s_unf, s_empty, s_count, s_rdata}), {24'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hA6});
        chk("clr_fwft", 64'({f_ovf, f_unf, f_empty, f_count}), {56'd0, 1'b0, 1'b0, 1'b1, 5'd0});

        // asynchronous reset in the middle of a write burst
        fill(3, 32'hF0);
        wen = 1'b1; wdata = 32'hF3;
        step(2);
        chk("burst_count", 64'(s_count), 64'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_fwft", f_vec(), RST_VEC);
        chk("async_rst_std", s_vec(), RST_VEC);
        wen = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_sync_fifo.md
Name: dma_sync_fifo

Overview:
Parametrised single-clock FIFO for the DMA datapath (read/write buffering between AXI/AHB masters and the channel engine). Wraps an inferred 1-cycle-latency simple dual-port RAM and adds pointer management, occupancy count, programmable almost-full/almost-empty flags, optional first-word-fall-through (FWFT) read mode, sticky overflow/underflow errors and synchronous flush. It is the generalised successor to the fixed-width RAM FIFO wrapper, which had no flag or pointer logic.

Parameters:
WIDTH, 128, data width in bits (1..1024)
DEPTH_LOG2, 7, log2 of RAM entries; DEPTH = 2**DEPTH_LOG2 (2..12)
FWFT, 1, 1 = first-word-fall-through; 0 = standard mode (data one cycle after REN)
AF_LEVEL, DEPTH-4, ALMOST_FULL asserted when COUNT >= AF_LEVEL
AE_LEVEL, 4, ALMOST_EMPTY asserted when COUNT <= AE_LEVEL

Ports:
CLOCK  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-high reset
CLR  in  1  synchronous flush: empties FIFO, clears sticky errors
WEN  in  1  write request
WDATA  in  WIDTH  write data
REN  in  1  read request (FWFT: pop; standard: fetch)
RDATA  out  WIDTH  read data
RVALID  out  1  standard mode: RDATA valid this cycle; FWFT: equals ~EMPTY
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  no word available to read
ALMOST_FULL  out  1  COUNT >= AF_LEVEL
ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL
COUNT  out  DEPTH_LOG2+1  words held (RAM plus FWFT output register)
OVERFLOW  out  1  sticky: WEN while FULL
UNDERFLOW  out  1  sticky: REN while EMPTY

Behaviour:
- Clocking/reset: one clock CLOCK; RESET asynchronous, active-high. Reset values: RDATA=0, RVALID=0, FULL=0, EMPTY=1, ALMOST_FULL=0, ALMOST_EMPTY=1, COUNT=0, OVERFLOW=0, UNDERFLOW=0, all pointers 0. RAM contents not reset.
- Pointers: wr_ptr/rd_ptr DEPTH_LOG2+1 bits, wrap modulo 2*DEPTH; address = low DEPTH_LOG2 bits. No extra logic at wrap beyond natural rollover.
- Write accepted iff WEN && !FULL && !CLR. WEN while FULL: write dropped, OVERFLOW set, including when REN is asserted in the same cycle (no pass-through at full).
- Read accepted iff REN && !EMPTY && !CLR. REN while EMPTY: ignored, UNDERFLOW set, including when WEN is asserted in the same cycle.
- Simultaneous accepted write and read: COUNT unchanged.
- COUNT, FULL, ALMOST_* are registered; each updates on the edge that accepts the operation.
- Standard mode (FWFT=0): accepted REN at edge N gives RDATA valid with RVALID=1 for one cycle after edge N+1. RDATA holds its last value otherwise. EMPTY deasserts on the edge accepting the first write.
- FWFT mode: internal output register and prefetch FSM with states IDLE (output reg empty), FETCH (RAM read in flight), VALID (output reg holds head word).
  - IDLE->FETCH when RAM is non-empty.
  - FETCH->VALID after one edge.
  - VALID->FETCH on pop if RAM is non-empty, else VALID->IDLE.
  - Pop in VALID with RAM non-empty: RDATA updates after 1 edge with a one-cycle EMPTY bubble. Back-to-back pops at full rate are not required.
  - Write to empty FIFO at edge N: EMPTY falls after edge N+2, RDATA = written word.
  - EMPTY = (state != VALID). RVALID = ~EMPTY.
- CLR: pointers, COUNT and FSM return to reset state on the next edge, errors cleared, RDATA unchanged. CLR dominates WEN/REN in the same cycle.
- RESET mid-operation discards all contents immediately.
- Elaboration check: AF_LEVEL <= DEPTH and AE_LEVEL < DEPTH, else $error.

Decomposition:
- Package dma_fifo_pkg: FSM state enum (IDLE/FETCH/VALID), clog2 helper, FIFO error-code constants shared with the channel status register.
- Sub-module dma_fifo_ram: inferred simple dual-port RAM, WIDTH x DEPTH, registered read, no reset on the array.

Test Plan (WIDTH=32, DEPTH_LOG2=4, AF_LEVEL=12, AE_LEVEL=2):
1. Reset, then write 0xA0..0xAF (16 words) -> COUNT=16, FULL=1, ALMOST_FULL=1 from the 12th write. A 17th WEN sets OVERFLOW=1 and COUNT stays 16.
2. FWFT=1, single write 0x1234 at edge N -> EMPTY=0, RDATA=0x1234 after edge N+2. Pop -> EMPTY=1, COUNT=0.
3. FWFT=0, fill 3 words, then REN each cycle -> RDATA=w0,w1,w2 with RVALID one cycle after each REN. A 4th REN sets UNDERFLOW=1.
4. Wrap: 40 writes interleaved with reads, occupancy kept at 5 -> read order matches write order across 2+ pointer wraps, COUNT=5 steady.
5. Simultaneous WEN+REN at FULL -> write dropped, OVERFLOW=1, COUNT=15. Simultaneous WEN+REN at EMPTY -> write accepted, UNDERFLOW=1, COUNT=1.
6. CLR with COUNT=9 and both error flags set -> next cycle COUNT=0, EMPTY=1, OVERFLOW=UNDERFLOW=0. Async RESET pulse mid-burst -> all outputs return to reset values immediately.
